// File: rtl/piezo_tune_seq.sv
// rtl/piezo_tune_seq.sv - six-note piezo tune sequencer with tick timing, repeat count and inter-tune gap
module piezo_tune_seq #(
  parameter int TICK_CYCLES = 500000,
  parameter int GAP_TICKS   = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  repeat_cnt,
  output logic        tone_en,
  output logic [14:0] note_per,
  output logic        clr,
  output logic        busy,
  output logic        done,
  output logic [2:0]  note_idx,
  output logic [2:0]  state
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    PLAY = 3'b010,
    GAP  = 3'b100
  } state_t;

  state_t          st;
  logic [TW-1:0]   tick_cnt;
  logic [7:0]      dur_cnt;
  logic [3:0]      reps_left;
  logic            loop_mode;
  logic            tick_last;
  logic            note_end;
  logic            gap_end;

  function automatic logic [14:0] rom_per(input logic [2:0] i);
    case (i)
      3'd0:    rom_per = 15'd31888;
      3'd1:    rom_per = 15'd23889;
      3'd2:    rom_per = 15'd18961;
      3'd3:    rom_per = 15'd15944;
      3'd4:    rom_per = 15'd18961;
      3'd5:    rom_per = 15'd15944;
      default: rom_per = 15'd0;
    endcase
  endfunction

  function automatic logic [7:0] rom_ticks(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: rom_ticks = 8'd30;
      3'd3:             rom_ticks = 8'd60;
      3'd4:             rom_ticks = 8'd15;
      3'd5:             rom_ticks = 8'd90;
      default:          rom_ticks = 8'd1;
    endcase
  endfunction

  // Counters are zero on every clr cycle, so the last cycle of a note is tick=max, dur=ticks-1.
  assign tick_last = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign note_end  = tick_last && (dur_cnt == rom_ticks(note_idx) - 8'd1);
  assign gap_end   = tick_last && (dur_cnt == 8'(GAP_TICKS - 1));
  assign state     = st;
  assign busy      = (st != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n || stop) begin
      st        <= IDLE;
      tone_en   <= 1'b0;
      note_per  <= 15'd0;
      clr       <= 1'b0;
      done      <= 1'b0;
      note_idx  <= 3'd0;
      tick_cnt  <= '0;
      dur_cnt   <= 8'd0;
      reps_left <= 4'd0;
      loop_mode <= 1'b0;
    end else begin
      clr  <= 1'b0;
      done <= 1'b0;
      if (tick_last) begin
        tick_cnt <= '0;
        dur_cnt  <= dur_cnt + 8'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      case (st)
        IDLE: begin
          tick_cnt <= '0;
          dur_cnt  <= 8'd0;
          if (start) begin
            st        <= PLAY;
            note_idx  <= 3'd0;
            note_per  <= rom_per(3'd0);
            tone_en   <= 1'b1;
            clr       <= 1'b1;
            reps_left <= repeat_cnt;
            loop_mode <= (repeat_cnt == 4'd0);
          end
        end
        PLAY: begin
          if (note_end) begin
            tick_cnt <= '0;
            dur_cnt  <= 8'd0;
            if (note_idx != 3'd5) begin
              note_idx <= note_idx + 3'd1;
              note_per <= rom_per(note_idx + 3'd1);
              clr      <= 1'b1;
            end else if (loop_mode || reps_left > 4'd1) begin
              if (!loop_mode)
                reps_left <= reps_left - 4'd1;
              st       <= GAP;
              tone_en  <= 1'b0;
              note_per <= 15'd0;
              note_idx <= 3'd0;
            end else begin
              st       <= IDLE;
              done     <= 1'b1;
              tone_en  <= 1'b0;
              note_per <= 15'd0;
              note_idx <= 3'd0;
            end
          end
        end
        GAP: begin
          if (gap_end) begin
            st       <= PLAY;
            tick_cnt <= '0;
            dur_cnt  <= 8'd0;
            note_idx <= 3'd0;
            note_per <= rom_per(3'd0);
            tone_en  <= 1'b1;
            clr      <= 1'b1;
          end
        end
        default: begin
          st       <= IDLE;
          tone_en  <= 1'b0;
          note_per <= 15'd0;
          note_idx <= 3'd0;
          tick_cnt <= '0;
          dur_cnt  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piezo_tune_seq.sv
// tb/tb_piezo_tune_seq.sv - scoreboard bench for piezo_tune_seq with TICK_CYCLES=4, GAP_TICKS=3
module tb_piezo_tune_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  repeat_cnt = 4'd0;
  logic        tone_en;
  logic [14:0] note_per;
  logic        clr;
  logic        busy;
  logic        done;
  logic [2:0]  note_idx;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_clr = 1'b0;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [14:0] per;
    logic [2:0]  idx;
  } ev_t;
  ev_t exp_q[$];

  int          clr_off[6] = '{1, 121, 241, 361, 601, 661};
  logic [14:0] rom_p[6]   = '{15'd31888, 15'd23889, 15'd18961, 15'd15944, 15'd18961, 15'd15944};

  piezo_tune_seq #(.TICK_CYCLES(4), .GAP_TICKS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .repeat_cnt(repeat_cnt),
    .tone_en(tone_en), .note_per(note_per), .clr(clr), .busy(busy), .done(done),
    .note_idx(note_idx), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every clr/done pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && (clr || done)) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d clr=%b done=%b idx=%0d per=%0d required=none",
                 cyc, clr, done, note_idx, note_per);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        checks++;
        if (e.is_done !== done || e.cyc != cyc ||
            (!e.is_done && (note_per !== e.per || note_idx !== e.idx))) begin
          errors++;
          $display("FAIL event cyc=%0d done=%b idx=%0d per=%0d required cyc=%0d done=%b idx=%0d per=%0d",
                   cyc, done, note_idx, note_per, e.cyc, e.is_done, e.idx, e.per);
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (state != 3'b001 && state != 3'b010 && state != 3'b100 ||
        busy !== !state[0] ||
        (tone_en && note_per == 15'd0) ||
        (clr && prev_clr) ||
        (clr && state != 3'b010)) begin
      errors++;
      $display("FAIL invariant cyc=%0d state=%b busy=%b tone_en=%b per=%0d clr=%b prev_clr=%b",
               cyc, state, busy, tone_en, note_per, clr, prev_clr);
    end
    prev_clr = clr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_pass(input int base, input int off, input bit with_done);
    for (int k = 0; k < 6; k++) begin
      ev_t e;
      e.is_done = 1'b0;
      e.cyc = base + off + clr_off[k];
      e.per = rom_p[k];
      e.idx = 3'(k);
      exp_q.push_back(e);
    end
    if (with_done) begin
      ev_t d;
      d.is_done = 1'b1;
      d.cyc = base + off + 1021;
      d.per = 15'd0;
      d.idx = 3'd0;
      exp_q.push_back(d);
    end
  endtask

  task automatic start_tune(input logic [3:0] rc, output int base);
    @(negedge clk);
    start = 1'b1;
    repeat_cnt = rc;
    base = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'h1);
    chk({tag, "_tone_en"}, 32'(tone_en), 32'h0);
    chk({tag, "_note_per"}, 32'(note_per), 32'h0);
    chk({tag, "_clr"}, 32'(clr), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_note_idx"}, 32'(note_idx), 32'h0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Single pass
    push_pass(cyc + 1, 0, 1'b1);
    start_tune(4'd1, base);
    wait_until(base + 1023);
    chk("single_end_state", 32'(state), 32'h1);
    chk("single_end_tone_en", 32'(tone_en), 32'h0);
    chk("single_queue_empty", 32'(exp_q.size()), 32'h0);

    // Two passes with gap; re-pulsed start and repeat_cnt change mid-tune ignored
    push_pass(cyc + 1, 0, 1'b0);
    push_pass(cyc + 1, 1032, 1'b1);
    start_tune(4'd2, base);
    wait_until(base + 200);
    start = 1'b1;
    repeat_cnt = 4'd1;
    @(negedge clk);
    start = 1'b0;
    chk("repulse_note_idx", 32'(note_idx), 32'h1);
    wait_until(base + 1020);
    chk("pre_gap_tone_en", 32'(tone_en), 32'h1);
    wait_until(base + 1021);
    chk("gap_state", 32'(state), 32'h4);
    chk("gap_tone_en", 32'(tone_en), 32'h0);
    chk("gap_note_per", 32'(note_per), 32'h0);
    wait_until(base + 1032);
    chk("gap_last_tone_en", 32'(tone_en), 32'h0);
    wait_until(base + 1033);
    chk("post_gap_tone_en", 32'(tone_en), 32'h1);
    wait_until(base + 2055);
    chk("double_end_state", 32'(state), 32'h1);
    chk("double_queue_empty", 32'(exp_q.size()), 32'h0);

    // Loop mode, then stop in note 3 of the fourth pass
    for (int p = 0; p < 3; p++) push_pass(cyc + 1, p * 1032, 1'b0);
    for (int k = 0; k < 4; k++) begin
      ev_t e;
      e.is_done = 1'b0;
      e.cyc = cyc + 1 + 3096 + clr_off[k];
      e.per = rom_p[k];
      e.idx = 3'(k);
      exp_q.push_back(e);
    end
    start_tune(4'd0, base);
    wait_until(base + 3096 + 450);
    chk("loop_note_idx", 32'(note_idx), 32'h3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_state", 32'(state), 32'h1);
    chk("stop_tone_en", 32'(tone_en), 32'h0);
    chk("stop_done", 32'(done), 32'h0);
    chk("loop_queue_empty", 32'(exp_q.size()), 32'h0);

    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_state", 32'(state), 32'h1);
    chk("startstop_busy", 32'(busy), 32'h0);
    repeat (5) @(negedge clk);

    // Reset during GAP, then clean restart
    push_pass(cyc + 1, 0, 1'b0);
    start_tune(4'd2, base);
    wait_until(base + 1025);
    chk("pre_reset_gap_state", 32'(state), 32'h4);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("gap_reset");
    rst_n = 1'b1;
    push_pass(cyc + 1, 0, 1'b1);
    start_tune(4'd1, base);
    wait_until(base + 1023);
    chk("restart_end_state", 32'(state), 32'h1);
    chk("restart_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piezo_tune_seq.md
Name: piezo_tune_seq

Overview:
- Sequencer that drives the piezo tone datapath (frequency counter plus square-wave output) through a fixed six-note tune.
- It generates note_per, tone_en and a per-note clr pulse, and times each note with an internal 10 ms tick.
- The tune repeats a programmable number of times with a silent gap between repetitions.
- It sits between the alarm/UI control logic (start/stop) and the tone generator.

Parameters:
- TICK_CYCLES, 500000: clk cycles per duration tick (10 ms at 50 MHz); set to 4 in simulation.
- GAP_TICKS, 100: silent ticks between repetitions (range 1..255).

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  synchronous active-low reset
- start  input  1  level/pulse; begins tune when idle
- stop  input  1  aborts tune immediately
- repeat_cnt  input  4  plays per start; 0 = loop until stop; sampled on accepted start
- tone_en  output  1  enables the tone generator output
- note_per  output  15  period of current note in clk cycles
- clr  output  1  one-cycle pulse at every note start; clears the tone generator's freq counter
- busy  output  1  high in PLAY or GAP
- done  output  1  one-cycle pulse on natural completion (not on stop)
- note_idx  output  3  index of current note (0..5)
- state  output  3  one-hot debug: IDLE=001, PLAY=010, GAP=100

Behaviour:
- Note ROM (idx: note_per, ticks): 0: 31888, 30; 1: 23889, 30; 2: 18961, 30; 3: 15944, 60; 4: 18961, 15; 5: 15944, 90. One repetition is 255 ticks.
- Reset (rst_n low at a clk edge): state=IDLE, tone_en=0, note_per=0, clr=0, busy=0, done=0, note_idx=0. Tick and duration counters and the repetition counter are cleared.
- Reset mid-tune returns to IDLE on the same edge.
- IDLE:
  - Outputs idle values.
  - start=1 and stop=0 at edge t: at t+1 state=PLAY, note_idx=0, note_per=31888, tone_en=1, clr=1 for one cycle.
  - reps_left is loaded with repeat_cnt.
- PLAY:
  - Each note lasts exactly ticks*TICK_CYCLES cycles, measured from its clr cycle.
  - The tick prescaler restarts at 0 on every clr.
  - When the duration expires on note k<5: the next cycle loads note k+1 (note_per, note_idx) with clr=1 and tone_en staying 1. There are no dead cycles between notes.
  - When the duration expires on note 5:
    - If repeat_cnt was 0 (loop) or reps_left>1: decrement reps_left (not in loop mode) and go to GAP with tone_en=0 and note_per=0.
    - Otherwise: go to IDLE with done=1 for that one cycle.
- GAP:
  - Silent for GAP_TICKS*TICK_CYCLES cycles.
  - Then PLAY at idx 0 with a clr pulse, identical to the start entry.
- stop:
  - stop=1 in any state forces IDLE next cycle; tone_en=0 next cycle; done is not asserted.
  - stop has priority over start in the same cycle.
- start while busy is ignored; repeat_cnt changes mid-tune have no effect.
- busy equals (state != IDLE). clr is never asserted in IDLE or GAP.
- Counter widths:
  - Tick prescaler: wide enough for TICK_CYCLES-1, which is 19 bits at the default.
  - Duration counter: 8 bits.
  - reps_left: 4 bits.
  - No wraparound is reachable.
- The state register is the only encoding visible on state; no illegal state may persist. Any unreachable encoding recovers to IDLE next cycle.

Test Plan:
- Reset then start pulse with repeat_cnt=1, TICK_CYCLES=4:
  - clr pulses at cycles 1, 121, 241, 361, 601, 661 after start.
  - note_per follows the ROM.
  - done pulses at cycle 1021, then IDLE with tone_en=0.
- repeat_cnt=2, GAP_TICKS=3: after the first pass, tone_en=0 for exactly 12 cycles, then clr with note_per=31888. done fires after the second pass only.
- repeat_cnt=0: the tune loops at least 3 times with no done. stop mid note 3 gives state=001 and tone_en=0 on the next cycle, with done=0.
- start and stop both high in IDLE: remains IDLE, busy=0. start re-pulsed during PLAY has no effect on note_idx or timing.
- rst_n low for one cycle during GAP: all outputs return to reset values on that edge. A following start restarts cleanly at idx 0.
- Assertions throughout: clr is exactly one cycle; state is always one-hot; busy == !state[0]; note_per != 0 whenever tone_en=1.
